// File: rtl/sdram_pic_wr_packer.sv
// Packs the SD loader's RGB565 pixel stream into SDRAM burst writes through a show-ahead FIFO.
// Keeps a running write address per picture and flushes residual words at the old address on a switch.
module sdram_pic_wr_packer #(
  parameter int  BURST_LEN  = 256,
  parameter int  FIFO_DEPTH = 1024,
  parameter int  ADDR_W     = 24,
  parameter int  LEN_W      = 9,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_wr_en,
  input  logic [15:0]       pix_wr_data,
  input  logic [ADDR_W-1:0] pix_base_addr,
  input  logic              pic_switch,
  input  logic              pic_load_done,
  output logic              sdram_wr_req,
  output logic [ADDR_W-1:0] sdram_wr_addr,
  output logic [LEN_W-1:0]  sdram_wr_len,
  input  logic              sdram_wr_ack,
  input  logic              sdram_rd_en,
  output logic [15:0]       sdram_rd_data,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              overflow,
  output logic              flush_done
);

  localparam int               PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] BURST_LVL = LVL_W'(BURST_LEN);
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] new_base_q, new_base_d;
  logic              flush_pend_q, flush_pend_d;
  logic [LVL_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  pop_cnt_q, pop_cnt_d;
  logic [LVL_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic              flush_done_q, flush_done_d;

  logic [LVL_W-1:0]  level;
  logic [LVL_W-1:0]  inflight;
  logic              full, push, pop;
  logic [15:0]       mem [FIFO_DEPTH];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    new_base_d   = new_base_q;
    flush_pend_d = flush_pend_q;
    flush_cnt_d  = flush_cnt_q;
    len_d        = len_q;
    pop_cnt_d    = pop_cnt_q;
    inflight     = '0;

    level = wr_ptr_q - rd_ptr_q;
    full  = (level == DEPTH_LVL);
    pop   = (state_q == S_XFER) && sdram_rd_en && (level != '0);
    push  = pix_wr_en && (!full || pop);

    wr_ptr_d   = wr_ptr_q + LVL_W'(push);
    rd_ptr_d   = rd_ptr_q + LVL_W'(pop);
    overflow_d = overflow_q | (pix_wr_en & ~push);

    unique case (state_q)
      S_IDLE: begin
        // A switch pulse defers any launch by one cycle so the flush count never includes a burst just issued.
        if (!pic_switch) begin
          if (flush_pend_q) begin
            if (flush_cnt_q == '0) begin
              cur_addr_d   = new_base_q;
              flush_pend_d = 1'b0;
            end else begin
              len_d       = (flush_cnt_q >= BURST_LVL) ? LEN_W'(BURST_LEN) : LEN_W'(flush_cnt_q);
              flush_cnt_d = flush_cnt_q - LVL_W'(len_d);
              state_d     = S_REQ;
            end
          end else if (level >= BURST_LVL) begin
            len_d   = LEN_W'(BURST_LEN);
            state_d = S_REQ;
          end else if (pic_load_done && (level != '0)) begin
            len_d   = LEN_W'(level);
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        inflight = LVL_W'(len_q);
        if (sdram_wr_ack) begin
          pop_cnt_d = '0;
          state_d   = S_XFER;
        end
      end
      S_XFER: begin
        inflight = LVL_W'(len_q) - LVL_W'(pop_cnt_q);
        if (pop) begin
          if (pop_cnt_q + LEN_W'(1) == len_q) begin
            cur_addr_d = cur_addr_q + ADDR_W'(len_q);
            state_d    = S_IDLE;
          end else begin
            pop_cnt_d = pop_cnt_q + LEN_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Words already committed to a requested burst are not part of the residual to flush.
    if (pic_switch) begin
      flush_pend_d = 1'b1;
      new_base_d   = pix_base_addr;
      flush_cnt_d  = level + LVL_W'(push) - inflight;
    end

    flush_done_d = pic_load_done && (state_d == S_IDLE) && (wr_ptr_d == rd_ptr_d) && !flush_pend_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      new_base_q   <= '0;
      flush_pend_q <= 1'b0;
      flush_cnt_q  <= '0;
      len_q        <= '0;
      pop_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      new_base_q   <= new_base_d;
      flush_pend_q <= flush_pend_d;
      flush_cnt_q  <= flush_cnt_d;
      len_q        <= len_d;
      pop_cnt_q    <= pop_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      flush_done_q <= flush_done_d;
    end
  end

  // NOTE: the storage array is not reset; emptiness is defined by the pointers, which are.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[PTR_W-1:0]] <= pix_wr_data;
  end

  assign sdram_wr_req  = (state_q == S_REQ);
  assign sdram_wr_addr = cur_addr_q;
  assign sdram_wr_len  = len_q;
  assign sdram_rd_data = mem[rd_ptr_q[PTR_W-1:0]];
  assign fifo_level    = level;
  assign overflow      = overflow_q;
  assign flush_done    = flush_done_q;

endmodule

// File: tb/tb_sdram_pic_wr_packer.sv
// Self-checking bench for sdram_pic_wr_packer: directed picture scenarios plus random traffic
// scored against a per-word model (each word carries its picture and target address).
module tb_sdram_pic_wr_packer;

  localparam int BURST_LEN  = 256;
  localparam int FIFO_DEPTH = 1024;
  localparam int ADDR_W     = 24;
  localparam int LEN_W      = 9;
  localparam int LVL_W      = 11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pix_wr_en;
  logic [15:0]       pix_wr_data;
  logic [ADDR_W-1:0] pix_base_addr;
  logic              pic_switch;
  logic              pic_load_done;
  logic              sdram_wr_req;
  logic [ADDR_W-1:0] sdram_wr_addr;
  logic [LEN_W-1:0]  sdram_wr_len;
  logic              sdram_wr_ack;
  logic              sdram_rd_en;
  logic [15:0]       sdram_rd_data;
  logic [LVL_W-1:0]  fifo_level;
  logic              overflow;
  logic              flush_done;

  always #10 clk = ~clk;

  sdram_pic_wr_packer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pix_wr_en     (pix_wr_en),
    .pix_wr_data   (pix_wr_data),
    .pix_base_addr (pix_base_addr),
    .pic_switch    (pic_switch),
    .pic_load_done (pic_load_done),
    .sdram_wr_req  (sdram_wr_req),
    .sdram_wr_addr (sdram_wr_addr),
    .sdram_wr_len  (sdram_wr_len),
    .sdram_wr_ack  (sdram_wr_ack),
    .sdram_rd_en   (sdram_rd_en),
    .sdram_rd_data (sdram_rd_data),
    .fifo_level    (fifo_level),
    .overflow      (overflow),
    .flush_done    (flush_done)
  );

  typedef struct {
    logic [15:0]       data;
    logic [ADDR_W-1:0] addr;
    int                pic;
  } word_t;

  // Reference model: buffered words in order, each tagged with its picture and SDRAM address.
  word_t             mq[$];
  int                cur_pic;
  logic [ADDR_W-1:0] pic_base;
  int                pic_idx;
  logic              ovf_exp;
  int                guard;

  // Controller emulation.
  int c_phase, c_delay, c_rem;
  int ack_delay, pull_pct;
  bit hold_ack;

  logic [ADDR_W-1:0] blog_addr[$];
  int                blog_len[$];

  bit                want_push, want_switch;
  logic [ADDR_W-1:0] sw_base;

  int checks, errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Expected burst length from the picture rules, evaluated when the request appears.
  function automatic int exp_len();
    int n = 0;
    if (mq.size() == 0) return 0;
    if (mq[0].pic != cur_pic) begin
      foreach (mq[i]) if (mq[i].pic == mq[0].pic) n++;
      return (n < BURST_LEN) ? n : BURST_LEN;
    end
    if (pic_load_done) return (mq.size() < BURST_LEN) ? mq.size() : BURST_LEN;
    return BURST_LEN;
  endfunction

  task automatic step();
    logic  rd, ack;
    word_t w;
    @(negedge clk);
    check("fifo_level", 32'(fifo_level), 32'(mq.size()));
    rd  = 1'b0;
    ack = 1'b0;
    if (c_phase == 1) check("req_hold", 32'(sdram_wr_req), 1);
    if (c_phase == 0 && sdram_wr_req) begin
      check("wr_addr", 32'(sdram_wr_addr), (mq.size() > 0) ? 32'(mq[0].addr) : 32'hdead_beef);
      check("wr_len", 32'(sdram_wr_len), 32'(exp_len()));
      blog_addr.push_back(sdram_wr_addr);
      blog_len.push_back(int'(sdram_wr_len));
      c_rem   = int'(sdram_wr_len);
      c_delay = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
      c_phase = 1;
    end
    if (c_phase == 1) begin
      rd = ($urandom_range(0, 3) == 0);
      if (!hold_ack) begin
        if (c_delay == 0) begin
          ack     = 1'b1;
          c_phase = 2;
        end else begin
          c_delay--;
        end
      end
    end else if (c_phase == 2) begin
      rd = (int'($urandom % 100) < pull_pct);
      if (rd) begin
        if (mq.size() > 0) begin
          w = mq.pop_front();
          check("rd_data", 32'(sdram_rd_data), 32'(w.data));
        end else begin
          check("pull_past_model", 32'(c_rem), 0);
        end
        c_rem--;
        if (c_rem == 0) c_phase = 0;
      end
    end else begin
      rd = ($urandom_range(0, 3) == 0);
    end

    w.data = 16'($urandom);
    w.addr = pic_base + ADDR_W'(pic_idx);
    w.pic  = cur_pic;
    if (want_push) begin
      if (mq.size() < FIFO_DEPTH) begin
        mq.push_back(w);
        pic_idx++;
      end else begin
        ovf_exp = 1'b1;
      end
    end
    if (want_switch) begin
      cur_pic++;
      pic_base = sw_base;
      pic_idx  = 0;
    end
    if (want_switch || (mq.size() > 0 && mq[0].pic != cur_pic)) guard = 0;
    else guard++;

    pix_wr_en     = want_push;
    pix_wr_data   = w.data;
    pic_switch    = want_switch;
    pix_base_addr = sw_base;
    sdram_rd_en   = rd;
    sdram_wr_ack  = ack;
  endtask

  task automatic run(input int n);
    want_push   = 1'b0;
    want_switch = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_n(input int n);
    want_switch = 1'b0;
    want_push   = 1'b1;
    for (int i = 0; i < n; i++) step();
    want_push = 1'b0;
  endtask

  task automatic do_switch(input logic [ADDR_W-1:0] base);
    want_push   = 1'b0;
    want_switch = 1'b1;
    sw_base     = base;
    step();
    want_switch = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    want_push   = 1'b0;
    want_switch = 1'b0;
    while (!(mq.size() == 0 && c_phase == 0) && n < budget) begin
      step();
      n++;
    end
    check("drain_done", 32'(mq.size() == 0 && c_phase == 0), 1);
    run(3);
  endtask

  task automatic expect_burst(input int i, input logic [ADDR_W-1:0] a, input int l);
    check("burst_seen", 32'(blog_addr.size() > i), 1);
    if (blog_addr.size() > i) begin
      check("burst_addr", 32'(blog_addr[i]), 32'(a));
      check("burst_len", 32'(blog_len[i]), 32'(l));
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_req", 32'(sdram_wr_req), 0);
    check("rst_addr", 32'(sdram_wr_addr), 0);
    check("rst_len", 32'(sdram_wr_len), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_flush_done", 32'(flush_done), 0);
  endtask

  initial begin
    #1_600_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int n;
    checks = 0; errors = 0;
    mq.delete(); cur_pic = 0; pic_base = '0; pic_idx = 0; ovf_exp = 1'b0; guard = 0;
    c_phase = 0; c_delay = 0; c_rem = 0; ack_delay = 3; pull_pct = 100; hold_ack = 1'b0;
    want_push = 1'b0; want_switch = 1'b0; sw_base = '0;
    rst_n = 1'b0; pix_wr_en = 1'b0; pix_wr_data = '0; pix_base_addr = '0; pic_switch = 1'b0;
    pic_load_done = 1'b0; sdram_wr_ack = 1'b0; sdram_rd_en = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    run(2);

    // Continuous run: two full bursts at the picture base.
    blog_addr.delete(); blog_len.delete();
    do_switch(24'h0C0000);
    push_n(512);
    drain(3000);
    check("run_nbursts", 32'(blog_addr.size()), 2);
    expect_burst(0, 24'h0C0000, 256);
    expect_burst(1, 24'h0C0100, 256);

    // Residual flush at the old address, then rebase.
    blog_addr.delete(); blog_len.delete();
    do_switch(24'h000000);
    push_n(300);
    do_switch(24'h240000);
    push_n(256);
    drain(3000);
    expect_burst(0, 24'h000000, 256);
    expect_burst(1, 24'h000100, 44);
    expect_burst(2, 24'h240000, 256);

    // Word valid in the same cycle as the switch stays with the old picture.
    blog_addr.delete(); blog_len.delete();
    do_switch(24'h000000);
    push_n(255);
    want_push = 1'b1; want_switch = 1'b1; sw_base = 24'h100000;
    step();
    push_n(256);
    drain(3000);
    expect_burst(0, 24'h000000, 256);
    expect_burst(1, 24'h100000, 256);

    // Load done: short residual burst, then flush_done.
    blog_addr.delete(); blog_len.delete();
    do_switch(24'h300000);
    push_n(10);
    run(5);
    check("no_short_burst", 32'(blog_addr.size()), 0);
    pic_load_done = 1'b1;
    drain(500);
    expect_burst(0, 24'h300000, 10);
    check("flush_done_set", 32'(flush_done), 1);
    push_n(1);
    run(1);
    check("flush_done_drop", 32'(flush_done), 0);
    drain(500);
    pic_load_done = 1'b0;
    run(2);
    check("flush_done_clear", 32'(flush_done), 0);

    // Overflow: stall the controller and overfill.
    hold_ack = 1'b1;
    push_n(FIFO_DEPTH + 1);
    run(1);
    check("ovf_level", 32'(fifo_level), 32'(FIFO_DEPTH));
    check("ovf_flag", 32'(overflow), 1);
    hold_ack = 1'b0;
    drain(5000);
    check("ovf_sticky", 32'(overflow), 32'(ovf_exp));

    // Random traffic with occasional picture switches.
    ack_delay = -1; pull_pct = 70;
    for (int i = 0; i < 4000; i++) begin
      want_push   = ($urandom % 10) < 7;
      want_switch = (guard >= 3) && ($urandom % 300 == 0);
      sw_base     = ADDR_W'($urandom);
      step();
    end
    n = 0;
    want_push = 1'b0; want_switch = 1'b0;
    while (guard < 3 && n < 5000) begin step(); n++; end
    do_switch(ADDR_W'($urandom));
    drain(20000);
    check("rand_overflow", 32'(overflow), 32'(ovf_exp));

    // Reset in the middle of a transfer.
    ack_delay = 3; pull_pct = 100;
    push_n(256);
    n = 0;
    while (!(c_phase == 2 && c_rem == 156) && n < 2000) begin step(); n++; end
    check("mid_xfer_reached", 32'(c_phase == 2 && c_rem == 156), 1);
    pull_pct = 0;
    step();
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    mq.delete(); cur_pic++; pic_base = '0; pic_idx = 0; ovf_exp = 1'b0; guard = 0;
    c_phase = 0; c_rem = 0; pull_pct = 100;
    run(2);
    rst_n = 1'b1;
    run(2);
    blog_addr.delete(); blog_len.delete();
    do_switch(24'h26F400);
    push_n(256);
    drain(1000);
    check("post_rst_nbursts", 32'(blog_addr.size()), 1);
    expect_burst(0, 24'h26F400, 256);
    check("post_rst_overflow", 32'(overflow), 32'(ovf_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
